mem_arbiter: RTL and testbench

//  Sole driver of mem_unit control (mem_op, mem_src, mem_addr). Arbitrates single-beat

---
 rtl/mem_arbiter_if.sv | 71 +++++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared mem_unit encodings and the requester/mem_unit bundle seen by mem_arbiter.
// The arbiter takes the slave modport; the requester/memory side takes master.
package mem_arbiter_pkg;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned OWNER_W = 2;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_FROM_ACC    = 2'd0,
        MEM_FROM_ALU    = 2'd1,
        MEM_FROM_LOADER = 2'd2,
        MEM_FROM_CACHE  = 2'd3
    } mem_src_e;

    typedef enum logic [1:0] {
        ADDR_FROM_HEAD   = 2'd0,
        ADDR_FROM_ALU    = 2'd1,
        ADDR_FROM_LOADER = 2'd2,
        ADDR_FROM_CACHE  = 2'd3
    } mem_addr_e;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t OWN_NONE   = 2'd0;
    localparam owner_t OWN_LOADER = 2'd1;
    localparam owner_t OWN_CORE   = 2'd2;
    localparam owner_t OWN_CACHE  = 2'd3;
endpackage

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              loader_req;
    logic              loader_we;
    logic              loader_gnt;
    logic              core_req;
    logic              core_we;
    mem_src_e          core_src;
    mem_addr_e         core_addr;
    logic              core_gnt;
    logic              cache_req;
    logic              cache_we;
    logic              cache_gnt;
    mem_op_e           mem_op;
    mem_src_e          mem_src;
    mem_addr_e         mem_addr;
    logic [BYTE_W-1:0] mem_out;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;
    owner_t            rd_owner;
    logic              busy;

    modport slave (
        input  loader_req, loader_we, core_req, core_we, core_src, core_addr,
               cache_req, cache_we, mem_out,
        output loader_gnt, core_gnt, cache_gnt, mem_op, mem_src, mem_addr,
               rd_data, rd_valid, rd_owner, busy
    );

    modport master (
        output loader_req, loader_we, core_req, core_we, core_src, core_addr,
               cache_req, cache_we, mem_out,
        input  loader_gnt, core_gnt, cache_gnt, mem_op, mem_src, mem_addr,
               rd_data, rd_valid, rd_owner, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-beat arbiter in front of mem_unit: loader > core > cache with a core burst
// cap while cache waits; one access in flight, read data returned tagged with owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned CORE_BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int unsigned BURST_W = $clog2(CORE_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

    state_e               state_q;
    logic [LAT_W-1:0]     lat_q;
    logic [BURST_W-1:0]   burst_q;
    logic [BURST_W-1:0]   burst_d;
    owner_t               owner_q;
    logic                 rd_q;
    logic                 loader_gnt_q;
    logic                 core_gnt_q;
    logic                 cache_gnt_q;
    mem_op_e              mem_op_q;
    mem_src_e             mem_src_q;
    mem_addr_e            mem_addr_q;
    logic                 rd_valid_q;
    owner_t               rd_owner_q;
    logic                 busy_q;

    logic                 last_wait_c;
    logic                 arb_en_c;
    logic                 burst_full_c;
    owner_t               win_c;
    logic                 win_we_c;

    // Arbitration: open in IDLE, after a write issue, and in the final read-wait cycle.
    always_comb begin
        last_wait_c  = (state_q == ST_RD_WAIT) && (lat_q == '0);
        arb_en_c     = (state_q == ST_IDLE) || ((state_q == ST_ISSUE) && !rd_q) || last_wait_c;
        burst_full_c = (burst_q == BURST_W'(CORE_BURST));

        win_c = OWN_NONE;
        if (bus.loader_req) begin
            win_c = OWN_LOADER;
        end else if (bus.core_req && !(bus.cache_req && burst_full_c)) begin
            win_c = OWN_CORE;
        end else if (bus.cache_req) begin
            win_c = OWN_CACHE;
        end

        case (win_c)
            OWN_LOADER: win_we_c = bus.loader_we;
            OWN_CORE:   win_we_c = bus.core_we;
            OWN_CACHE:  win_we_c = bus.cache_we;
            default:    win_we_c = 1'b0;
        endcase
    end

    // Core grants are only counted against a waiting cache; any idle cache cycle forgives them.
    always_comb begin
        burst_d = burst_q;
        if (!bus.cache_req) begin
            burst_d = '0;
        end else if (arb_en_c && (win_c == OWN_CACHE)) begin
            burst_d = '0;
        end else if (arb_en_c && (win_c == OWN_CORE) && !burst_full_c) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            burst_q      <= '0;
            owner_q      <= OWN_NONE;
            rd_q         <= 1'b0;
            loader_gnt_q <= 1'b0;
            core_gnt_q   <= 1'b0;
            cache_gnt_q  <= 1'b0;
            mem_op_q     <= MEM_NOP;
            mem_src_q    <= MEM_FROM_ACC;
            mem_addr_q   <= ADDR_FROM_HEAD;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= OWN_NONE;
            busy_q       <= 1'b0;
        end else begin
            loader_gnt_q <= 1'b0;
            core_gnt_q   <= 1'b0;
            cache_gnt_q  <= 1'b0;
            mem_op_q     <= MEM_NOP;
            mem_src_q    <= MEM_FROM_ACC;
            mem_addr_q   <= ADDR_FROM_HEAD;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= OWN_NONE;
            burst_q      <= burst_d;

            if (arb_en_c) begin
                if (win_c != OWN_NONE) begin
                    state_q  <= ST_ISSUE;
                    busy_q   <= 1'b1;
                    owner_q  <= win_c;
                    rd_q     <= !win_we_c;
                    mem_op_q <= win_we_c ? MEM_WRITE : MEM_READ;
                    case (win_c)
                        OWN_LOADER: begin
                            loader_gnt_q <= 1'b1;
                            mem_src_q    <= MEM_FROM_LOADER;
                            mem_addr_q   <= ADDR_FROM_LOADER;
                        end
                        OWN_CORE: begin
                            core_gnt_q <= 1'b1;
                            mem_src_q  <= bus.core_src;
                            mem_addr_q <= bus.core_addr;
                        end
                        default: begin
                            cache_gnt_q <= 1'b1;
                            mem_src_q   <= MEM_FROM_CACHE;
                            mem_addr_q  <= ADDR_FROM_CACHE;
                        end
                    endcase
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (state_q == ST_ISSUE) begin
                // Read issue: rd_valid lands exactly in the last wait cycle.
                state_q <= ST_RD_WAIT;
                busy_q  <= 1'b1;
                lat_q   <= LAT_W'(READ_LAT - 1);
                if (READ_LAT == 1) begin
                    rd_valid_q <= 1'b1;
                    rd_owner_q <= owner_q;
                end
            end else begin
                busy_q <= 1'b1;
                lat_q  <= lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    rd_valid_q <= 1'b1;
                    rd_owner_q <= owner_q;
                end
            end
        end
    end

    assign bus.loader_gnt = loader_gnt_q;
    assign bus.core_gnt   = core_gnt_q;
    assign bus.cache_gnt  = cache_gnt_q;
    assign bus.mem_op     = mem_op_q;
    assign bus.mem_src    = mem_src_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_owner   = rd_owner_q;
    assign bus.busy       = busy_q;
    assign bus.rd_data    = bus.mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a READ_LAT=1 instance for arbitration and read
// return, and a READ_LAT=3 instance for long read latency and reset mid-read.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        owner_t    owner;
        mem_op_e   op;
        mem_src_e  src;
        mem_addr_e addr;
    } gnt_exp_t;

    typedef struct packed {
        owner_t            owner;
        logic [BYTE_W-1:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if bus1();
    mem_arbiter_if bus3();

    mem_arbiter #(.READ_LAT(1), .CORE_BURST(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    mem_arbiter #(.READ_LAT(3), .CORE_BURST(4)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];
    rd_exp_t  rq3[$];

    int ld_n, co_n, ca_n, co3_n;
    int cyc, gcyc1, gcyc3, busy_cnt, rd3_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_gnt(input owner_t o, input mem_op_e op, input mem_src_e s, input mem_addr_e a);
        gnt_exp_t e;
        e.owner = o;
        e.op    = op;
        e.src   = s;
        e.addr  = a;
        gq.push_back(e);
    endtask

    task automatic push_rd(input owner_t o, input logic [BYTE_W-1:0] d);
        rd_exp_t e;
        e.owner = o;
        e.data  = d;
        rq.push_back(e);
    endtask

    task automatic drive_reqs();
        bus1.loader_req = (ld_n != 0);
        bus1.core_req   = (co_n != 0);
        bus1.cache_req  = (ca_n != 0);
        bus3.core_req   = (co3_n != 0);
    endtask

    function automatic owner_t gnt_owner(input logic [2:0] gv);
        case (gv)
            3'b001:  return OWN_LOADER;
            3'b010:  return OWN_CORE;
            3'b100:  return OWN_CACHE;
            default: return OWN_NONE;
        endcase
    endfunction

    // Sampled on the falling edge: grants and read returns are matched against the queues.
    task automatic monitor();
        logic [2:0] gv;
        gnt_exp_t   ge;
        rd_exp_t    re;
        cyc++;
        if (!reset) return;
        if (bus1.busy) busy_cnt++;
        gv = {bus1.cache_gnt, bus1.core_gnt, bus1.loader_gnt};
        if (gv != 3'b000) begin
            gcyc1 = cyc;
            if (gq.size() == 0) begin
                check_eq("gnt_unexpected", 32'(gv), 32'(0));
            end else begin
                ge = gq.pop_front();
                check_eq("gnt_owner", 32'(gnt_owner(gv)), 32'(ge.owner));
                check_eq("gnt_mem_op", 32'(bus1.mem_op), 32'(ge.op));
                check_eq("gnt_mem_src", 32'(bus1.mem_src), 32'(ge.src));
                check_eq("gnt_mem_addr", 32'(bus1.mem_addr), 32'(ge.addr));
                check_eq("gnt_busy", 32'(bus1.busy), 32'(1));
            end
        end else if (bus1.mem_op != MEM_NOP) begin
            check_eq("op_without_gnt", 32'(bus1.mem_op), 32'(MEM_NOP));
        end
        if (bus1.rd_valid) begin
            if (rq.size() == 0) begin
                check_eq("rd_unexpected", 32'(bus1.rd_owner), 32'(0));
            end else begin
                re = rq.pop_front();
                check_eq("rd_owner", 32'(bus1.rd_owner), 32'(re.owner));
                check_eq("rd_data", 32'(bus1.rd_data), 32'(re.data));
                check_eq("rd_latency", 32'(cyc - gcyc1), 32'(1));
            end
        end
        if (bus3.core_gnt) begin
            gcyc3 = cyc;
            check_eq("gnt3_mem_op", 32'(bus3.mem_op), 32'(MEM_READ));
        end
        if (bus3.rd_valid) begin
            rd3_seen++;
            if (rq3.size() == 0) begin
                check_eq("rd3_unexpected", 32'(bus3.rd_owner), 32'(0));
            end else begin
                re = rq3.pop_front();
                check_eq("rd3_owner", 32'(bus3.rd_owner), 32'(re.owner));
                check_eq("rd3_data", 32'(bus3.rd_data), 32'(re.data));
                check_eq("rd3_latency", 32'(cyc - gcyc3), 32'(3));
            end
        end
    endtask

    // One clock: monitor on the falling edge, then requesters react to grants just after the rise.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (bus1.loader_gnt && ld_n > 0) ld_n--;
        if (bus1.core_gnt && co_n > 0) co_n--;
        if (bus1.cache_gnt && ca_n > 0) ca_n--;
        if (bus3.core_gnt && co3_n > 0) co3_n--;
        drive_reqs();
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = (ld_n == 0) && (co_n == 0) && (ca_n == 0) && (co3_n == 0) &&
                   (gq.size() == 0) && (rq.size() == 0) && (rq3.size() == 0) &&
                   !bus1.busy && !bus3.busy;
        end
        if (!done) check_eq({tag, "_timeout"}, 32'(1), 32'(0));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_n = 0; co_n = 0; ca_n = 0; co3_n = 0;
        cyc = 0; gcyc1 = 0; gcyc3 = 0; busy_cnt = 0; rd3_seen = 0;
        bus1.loader_we = 1'b0; bus1.core_we = 1'b0; bus1.cache_we = 1'b0;
        bus1.core_src = MEM_FROM_ACC; bus1.core_addr = ADDR_FROM_HEAD;
        bus1.mem_out = '0;
        bus3.loader_req = 1'b0; bus3.loader_we = 1'b0; bus3.core_we = 1'b0;
        bus3.core_src = MEM_FROM_ACC; bus3.core_addr = ADDR_FROM_HEAD;
        bus3.cache_req = 1'b0; bus3.cache_we = 1'b0; bus3.mem_out = '0;
        drive_reqs();
        reset = 1'b0;
        #22;
        check_eq("rst_mem_op", 32'(bus1.mem_op), 32'(MEM_NOP));
        check_eq("rst_mem_src", 32'(bus1.mem_src), 32'(MEM_FROM_ACC));
        check_eq("rst_mem_addr", 32'(bus1.mem_addr), 32'(ADDR_FROM_HEAD));
        check_eq("rst_gnts", 32'({bus1.loader_gnt, bus1.core_gnt, bus1.cache_gnt}), 32'(0));
        check_eq("rst_rd_valid", 32'(bus1.rd_valid), 32'(0));
        check_eq("rst_rd_owner", 32'(bus1.rd_owner), 32'(0));
        check_eq("rst_busy", 32'(bus1.busy), 32'(0));
        reset = 1'b1;
        step();

        // Single core write, then the bus returns to idle values.
        bus1.core_we = 1'b1; bus1.core_src = MEM_FROM_ALU; bus1.core_addr = ADDR_FROM_HEAD;
        push_gnt(OWN_CORE, MEM_WRITE, MEM_FROM_ALU, ADDR_FROM_HEAD);
        co_n = 1; drive_reqs();
        wait_done("core_write");
        check_eq("idle_mem_op", 32'(bus1.mem_op), 32'(MEM_NOP));
        check_eq("idle_mem_src", 32'(bus1.mem_src), 32'(MEM_FROM_ACC));
        check_eq("idle_core_gnt", 32'(bus1.core_gnt), 32'(0));

        // Core read with one-cycle latency.
        bus1.core_we = 1'b0; bus1.core_src = MEM_FROM_ACC; bus1.core_addr = ADDR_FROM_ALU;
        bus1.mem_out = 8'hA3;
        push_gnt(OWN_CORE, MEM_READ, MEM_FROM_ACC, ADDR_FROM_ALU);
        push_rd(OWN_CORE, 8'hA3);
        busy_cnt = 0;
        co_n = 1; drive_reqs();
        wait_done("core_read");
        check_eq("core_read_busy_cycles", 32'(busy_cnt), 32'(2));

        // Three simultaneous single writes: fixed priority order in consecutive slots.
        bus1.loader_we = 1'b1; bus1.core_we = 1'b1; bus1.cache_we = 1'b1;
        bus1.core_src = MEM_FROM_ACC; bus1.core_addr = ADDR_FROM_ALU;
        push_gnt(OWN_LOADER, MEM_WRITE, MEM_FROM_LOADER, ADDR_FROM_LOADER);
        push_gnt(OWN_CORE, MEM_WRITE, MEM_FROM_ACC, ADDR_FROM_ALU);
        push_gnt(OWN_CACHE, MEM_WRITE, MEM_FROM_CACHE, ADDR_FROM_CACHE);
        busy_cnt = 0;
        ld_n = 1; co_n = 1; ca_n = 1; drive_reqs();
        wait_done("priority");
        check_eq("priority_busy_cycles", 32'(busy_cnt), 32'(3));

        // Core burst cap: cache gets a slot after every four core grants.
        bus1.core_src = MEM_FROM_ALU; bus1.core_addr = ADDR_FROM_ALU;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push_gnt(OWN_CORE, MEM_WRITE, MEM_FROM_ALU, ADDR_FROM_ALU);
            push_gnt(OWN_CACHE, MEM_WRITE, MEM_FROM_CACHE, ADDR_FROM_CACHE);
        end
        busy_cnt = 0;
        co_n = 8; ca_n = 2; drive_reqs();
        wait_done("burst");
        check_eq("burst_busy_cycles", 32'(busy_cnt), 32'(10));

        // Core held for three accesses: back-to-back write issues.
        bus1.core_src = MEM_FROM_ACC; bus1.core_addr = ADDR_FROM_HEAD;
        for (int i = 0; i < 3; i++) push_gnt(OWN_CORE, MEM_WRITE, MEM_FROM_ACC, ADDR_FROM_HEAD);
        busy_cnt = 0;
        co_n = 3; drive_reqs();
        wait_done("core_held");
        check_eq("core_held_busy_cycles", 32'(busy_cnt), 32'(3));

        // Loader and cache reads: next issue starts right after the read return cycle.
        bus1.loader_we = 1'b0; bus1.cache_we = 1'b0; bus1.mem_out = 8'h5C;
        push_gnt(OWN_LOADER, MEM_READ, MEM_FROM_LOADER, ADDR_FROM_LOADER);
        push_gnt(OWN_CACHE, MEM_READ, MEM_FROM_CACHE, ADDR_FROM_CACHE);
        push_rd(OWN_LOADER, 8'h5C);
        push_rd(OWN_CACHE, 8'h5C);
        busy_cnt = 0;
        ld_n = 1; ca_n = 1; drive_reqs();
        wait_done("reads");
        check_eq("reads_busy_cycles", 32'(busy_cnt), 32'(4));

        // Three-cycle read on the second instance.
        bus3.core_we = 1'b0; bus3.mem_out = 8'h3C;
        rq3.push_back('{owner: OWN_CORE, data: 8'h3C});
        co3_n = 1; drive_reqs();
        wait_done("read_lat3");
        check_eq("read_lat3_returned", 32'(rd3_seen), 32'(1));

        // Reset while waiting on a read: bus idles at once, no late return.
        co3_n = 1; drive_reqs();
        for (int i = 0; i < 10 && !bus3.core_gnt; i++) step();
        check_eq("rst_mid_gnt_seen", 32'(bus3.core_gnt), 32'(1));
        step();
        #1;
        check_eq("rst_mid_busy_before", 32'(bus3.busy), 32'(1));
        reset = 1'b0;
        #1;
        check_eq("rst_mid_mem_op", 32'(bus3.mem_op), 32'(MEM_NOP));
        check_eq("rst_mid_busy", 32'(bus3.busy), 32'(0));
        check_eq("rst_mid_rd_valid", 32'(bus3.rd_valid), 32'(0));
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("rst_mid_no_return", 32'(rd3_seen), 32'(1));
        check_eq("rst_mid_idle_busy", 32'(bus3.busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
